caf_shift_streamer: RTL
=======================

CAF_SHIFT_STREAMER -- requirements
Module: caf_shift_streamer

Interface
REQ-001 Parameter xi_bits, default 12, reference-sample I width.
REQ-002 Parameter xq_bits, default 12, reference-sample Q width.
REQ-003 Parameter yi_bits, default 12, received-sample I width.
REQ-004 Parameter yq_bits, default 12, received-sample Q width.
REQ-005 Parameter length, default 5, pairs per frame; SHALL satisfy 1 <= length <= 2**buffer_addr_bits.
REQ-006 Parameter length_counter_bits, default 3, frame-counter width; SHALL satisfy 2**length_counter_bits >= length.
REQ-007 Parameter buffer_addr_bits, default 4, buffer depth = 2**buffer_addr_bits.
REQ-008 Port list, one per line:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ref_wr_en  in  1  write strobe, reference buffer
- ref_wr_addr  in  buffer_addr_bits  reference write address
- ref_wr_i / ref_wr_q  in  xi_bits / xq_bits  reference sample
- rx_wr_en  in  1  write strobe, received buffer
- rx_wr_addr  in  buffer_addr_bits  received write address
- rx_wr_i / rx_wr_q  in  yi_bits / yq_bits  received sample
- start  in  1  begin one frame
- shift  in  buffer_addr_bits  circular lag applied to received buffer
- tready  in  1  downstream dot-product ready
- m_axis_x_tvalid / m_axis_y_tvalid  out  1  pair valid (always equal)
- xi / xq  out  xi_bits / xq_bits  reference sample out
- yi / yq  out  yi_bits / yq_bits  shifted received sample out
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse

Function
REQ-009 FSM states IDLE, PRIME, STREAM, FINISH; reset state IDLE.
REQ-010 IDLE: start=1 SHALL latch shift, clear pair counter n, assert busy next cycle, go PRIME.
REQ-011 Pair n SHALL be x = ref[n], y = rx[(n + shift_latched) mod 2**buffer_addr_bits]; wrap is natural address overflow.
REQ-012 PRIME: issue read for n=0; first valid pair SHALL appear on outputs 2 cycles after the start-accept cycle; then STREAM.
REQ-013 Both buffers SHALL have 1-cycle synchronous read latency.
REQ-014 A pair transfers on a cycle with valid=1 and tready=1; while valid=1 and tready=0, all x/y outputs and valid SHALL hold stable.
REQ-015 With tready held high, one pair SHALL transfer per cycle (no bubbles) from first valid to last.
REQ-016 Read address SHALL advance only when the output register is empty or transferring.
REQ-017 After pair length-1 transfers, valid SHALL drop next cycle, state FINISH; FINISH asserts done for exactly one cycle, deasserts busy, returns IDLE.
REQ-018 start while busy=1 or in FINISH SHALL be ignored.
REQ-019 Writes with busy=0 SHALL update the buffer at the next edge; writes while busy=1 SHALL be dropped.
REQ-020 start and a write in the same IDLE cycle: write SHALL complete before the frame's first read.
REQ-021 length=1: single pair, done 1 cycle after its transfer.
REQ-022 xi/xq/yi/yq are raw stored bits; no sign extension or scaling.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, valid=0, busy=0, done=0, xi/xq/yi/yq=0, counter=0, shift_latched=0.
REQ-024 rst mid-frame SHALL abort with no done pulse; buffer contents SHALL be preserved.
REQ-025 rst SHALL dominate start and writes in the same cycle.

Structure
REQ-026 Shared package caf_pkg SHALL hold FSM state encodings and default width constants (12-bit samples, 4-bit address).
REQ-027 Sub-module cpx_sample_ram (1 write port, 1 read port with enable, 1-cycle latency, I/Q widths parameterised) SHALL be instantiated twice.

Verification
REQ-028 ref[k]=k+1, rx[k]=16*(k+1), shift=0, tready=1, start -> pairs (1,16),(2,32)..(5,80) on consecutive cycles, done 1 cycle after last.
REQ-029 Same buffers, shift=14 -> y sequence rx[14],rx[15],rx[0],rx[1],rx[2] = 240,256,16,32,48.
REQ-030 tready low for 3 cycles during pair 2 -> pair 2 held unchanged for 3 cycles, no pair lost or duplicated, 5 total transfers.
REQ-031 start pulsed again during frame and rx_wr_en to addr 0 while busy -> second start ignored, rx[0] unchanged on next frame readback.
REQ-032 rst asserted after 2nd transfer -> valid=0, busy=0 next cycle, no done; next start replays full frame from n=0.
REQ-033 length=1 build, start -> exactly one pair (ref[0], rx[shift]), then done.

Source files
------------

// File: rtl/caf_pkg.sv
// Shared constants and FSM encoding for the cross-ambiguity-function sample streamer.
package caf_pkg;

  localparam int unsigned CafSampleBits = 12;
  localparam int unsigned CafAddrBits   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StStream,
    StFinish
  } caf_state_e;

endpackage

// File: rtl/cpx_sample_ram.sv
// Complex-sample RAM: one write port, one enabled read port with 1-cycle registered latency.
module cpx_sample_ram
  import caf_pkg::*;
#(
  parameter int unsigned i_bits    = CafSampleBits,
  parameter int unsigned q_bits    = CafSampleBits,
  parameter int unsigned addr_bits = CafAddrBits
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] wr_addr,
  input  logic [i_bits-1:0]    wr_i,
  input  logic [q_bits-1:0]    wr_q,
  input  logic                 rd_en,
  input  logic [addr_bits-1:0] rd_addr,
  output logic [i_bits-1:0]    rd_i,
  output logic [q_bits-1:0]    rd_q
);

  localparam int unsigned depth = 2 ** addr_bits;

  logic [i_bits-1:0] mem_i [depth];
  logic [q_bits-1:0] mem_q [depth];

  // Storage is not reset so contents survive an aborted frame.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_i[wr_addr] <= wr_i;
      mem_q[wr_addr] <= wr_q;
    end
  end

  // Read register holds its value while rd_en is low, acting as the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_i <= '0;
      rd_q <= '0;
    end else if (rd_en) begin
      rd_i <= mem_i[rd_addr];
      rd_q <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/caf_shift_streamer.sv
// Streams (ref[n], rx[n + shift]) pairs from two sample buffers to a dot-product engine.
module caf_shift_streamer
  import caf_pkg::*;
#(
  parameter int unsigned xi_bits             = CafSampleBits,
  parameter int unsigned xq_bits             = CafSampleBits,
  parameter int unsigned yi_bits             = CafSampleBits,
  parameter int unsigned yq_bits             = CafSampleBits,
  parameter int unsigned length              = 5,
  parameter int unsigned length_counter_bits = 3,
  parameter int unsigned buffer_addr_bits    = CafAddrBits
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ref_wr_en,
  input  logic [buffer_addr_bits-1:0] ref_wr_addr,
  input  logic [xi_bits-1:0]          ref_wr_i,
  input  logic [xq_bits-1:0]          ref_wr_q,
  input  logic                        rx_wr_en,
  input  logic [buffer_addr_bits-1:0] rx_wr_addr,
  input  logic [yi_bits-1:0]          rx_wr_i,
  input  logic [yq_bits-1:0]          rx_wr_q,
  input  logic                        start,
  input  logic [buffer_addr_bits-1:0] shift,
  input  logic                        tready,
  output logic                        m_axis_x_tvalid,
  output logic                        m_axis_y_tvalid,
  output logic [xi_bits-1:0]          xi,
  output logic [xq_bits-1:0]          xq,
  output logic [yi_bits-1:0]          yi,
  output logic [yq_bits-1:0]          yq,
  output logic                        busy,
  output logic                        done
);

  localparam logic [length_counter_bits-1:0] last_n = length_counter_bits'(length - 1);

  caf_state_e                    state_q, state_d;
  logic [length_counter_bits-1:0] n_q, n_d;
  logic [buffer_addr_bits-1:0]    shift_q, shift_d;
  logic                           valid_q, valid_d;
  logic                           rd_en;
  logic [buffer_addr_bits-1:0]    rd_addr_x, rd_addr_y;
  logic                           wr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q     <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      n_q     <= n_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  // n_q indexes the pair currently held in the RAM read registers.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    shift_d = shift_q;
    valid_d = valid_q;
    rd_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPrime;
          shift_d = shift;
          n_d     = '0;
        end
      end
      StPrime: begin
        rd_en   = 1'b1;
        valid_d = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        if (tready) begin
          if (n_q == last_n) begin
            valid_d = 1'b0;
            state_d = StFinish;
          end else begin
            n_d   = n_q + length_counter_bits'(1);
            rd_en = 1'b1;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StPrime) || (state_q == StStream);
    done = (state_q == StFinish);
  end

  assign m_axis_x_tvalid = valid_q;
  assign m_axis_y_tvalid = valid_q;

  assign rd_addr_x = buffer_addr_bits'(n_d);
  assign rd_addr_y = rd_addr_x + shift_q;
  assign wr_ok     = !busy && !rst;

  cpx_sample_ram #(
    .i_bits    (xi_bits),
    .q_bits    (xq_bits),
    .addr_bits (buffer_addr_bits)
  ) u_ref_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ref_wr_en && wr_ok),
    .wr_addr (ref_wr_addr),
    .wr_i    (ref_wr_i),
    .wr_q    (ref_wr_q),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_x),
    .rd_i    (xi),
    .rd_q    (xq)
  );

  cpx_sample_ram #(
    .i_bits    (yi_bits),
    .q_bits    (yq_bits),
    .addr_bits (buffer_addr_bits)
  ) u_rx_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_wr_en && wr_ok),
    .wr_addr (rx_wr_addr),
    .wr_i    (rx_wr_i),
    .wr_q    (rx_wr_q),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_y),
    .rd_i    (yi),
    .rd_q    (yq)
  );

endmodule
